branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits beside the program counter in IF and predicts next-PC for the current fetch address.
- Trained from ID, where branches resolve via the ID-stage comparator.
- Detects mispredicts and supplies the redirect PC. Replaces the static not-taken PC+4 policy.

Parameters:
- XLEN, 32, PC and target width.
- ENTRIES, 16, BTB entries; power of 2, >=2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits stored per entry.
- CTR_INIT, 2'b01, counter value written at reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_pc  in  XLEN  fetch PC being looked up
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  resolved branch in ID this cycle
- upd_pc  in  XLEN  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target (PC+imm)
- upd_pred_taken  in  1  prediction made for this branch (carried via IF/ID)
- upd_pred_target  in  XLEN  predicted next PC made for this branch
- mispredict  out  1  redirect required
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- stat_branches  out  32  resolved-branch count (see Optional Feature)
- stat_mispredicts  out  32  mispredict count (see Optional Feature)

Behaviour:
- Address fields:
  - index = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] ignored
- Per-entry state: valid (1b), tag (TAG_W), target (XLEN), ctr (2b). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, modulo 2^XLEN.
- Lookup reads pre-update state. An update at posedge N is visible to lookups from cycle N+1 onward. There is no same-cycle bypass, even when the update and lookup address the same index.
- Update (posedge clk, upd_valid=1):
  - Hit (valid & tag match): ctr increments if taken and decrements if not taken, saturating at 11/00. target <= upd_target only when taken.
  - Miss & taken: allocate/overwrite entry: valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss & not taken: no state change.
  - An aliasing entry (same index, different tag) is replaced only on a taken miss.
- Mispredict (combinational from update inputs):
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4. Valid only when mispredict=1; otherwise it is the same function, don't-care.
  - upd_valid=0 forces mispredict=0.
- Reset:
  - All valid<=0, ctr<=CTR_INIT, tag/target<=0.
  - Stat counters <=0.
  - Reset dominates a concurrent upd_valid; that update is dropped.
  - After reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Storage is flops (ENTRIES small). No read port latency.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments when mispredict=1.
  - Both saturate at 32'hFFFF_FFFF. Both are cleared by reset and do not count in the reset cycle.
- Undefined: no counter flops; stat_branches and stat_mispredicts tied to 0.

Test Plan:
- Cold lookup: reset, then if_pc=0x34 -> pred_hit=0, pred_taken=0, pred_target=0x38.
- Taken miss: upd_valid, upd_pc=0x34, taken, target=0x3C, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x3C. Next cycle if_pc=0x34 -> hit=1, taken=1, target=0x3C. In the update cycle itself, a lookup of 0x34 still gives hit=0.
- Hysteresis: from ctr=10 at 0x34, one not-taken update -> ctr=01, pred_taken=0, pred_target=0x38. Three taken updates -> ctr=11. One not-taken -> ctr=10, still predicts 0x3C.
- Aliasing: 0x74 (same index 0xD, tag 1) -> miss, pred_target=0x78. Not-taken update at 0x74 leaves the 0x34 entry intact. Taken update to 0x90 replaces it, so 0x34 then misses.
- Correct prediction: upd_taken=1, upd_pred_taken=1, targets equal -> mispredict=0. Targets 0x3C vs 0x40 -> mispredict=1, redirect_pc=0x3C.
- Reset mid-stream: reset asserted together with upd_valid -> table cleared, update dropped. With BP_STATS_EN: counts=0 and count correctly afterwards (e.g. 5 updates, 2 mispredicts -> 5/2).

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit
// saturating counter per entry. Looks up the fetch PC combinationally,
// trains from branch resolution in ID, and flags mispredicts together with
// the PC to fetch from instead.
//
// Optional feature: define BP_STATS_EN to get saturating resolved-branch
// and mispredict counters on stat_branches / stat_mispredicts. Without it,
// no counter flops are built and both outputs read zero.
module branch_predictor #(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  // IF-stage lookup
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  // ID-stage training
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  // statistics
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [1:0]      CTR_WT   = 2'b10;
  localparam logic [1:0]      CTR_MAX  = 2'b11;
  localparam logic [1:0]      CTR_MIN  = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];

  // ---------------------------------------------------------------------
  // Lookup: reads only the registered table, so an update lands one cycle
  // after it is presented, even when it hits the index being fetched.
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_entry;

  assign lk_idx   = if_pc[IDX_W+1:2];
  assign lk_tag   = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_entry = btb_q[lk_idx];

  // Predict taken only on a tag hit whose counter sits in a taken state.
  always_comb begin
    pred_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
    pred_taken  = pred_hit && lk_entry.ctr[1];
    pred_target = pred_taken ? lk_entry.target : if_pc + PC_STEP;
  end

  // ---------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_entry;
  entry_t           upd_entry_d;
  logic             upd_hit;
  logic             upd_write;

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_entry = btb_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // Work out the replacement entry: train a hit, allocate on a taken miss,
  // and leave aliasing entries alone on a not-taken miss.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch can be inferred.
    upd_entry_d = upd_entry;
    upd_write   = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          upd_entry_d.target = upd_target;
          if (upd_entry.ctr != CTR_MAX) upd_entry_d.ctr = upd_entry.ctr + 2'd1;
        end else begin
          if (upd_entry.ctr != CTR_MIN) upd_entry_d.ctr = upd_entry.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        upd_write          = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = upd_tag;
        upd_entry_d.target = upd_target;
        upd_entry_d.ctr    = CTR_WT;
      end
    end
  end

  // Table storage; reset wins over a concurrent update.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is flops, so every entry is cleared here and the
      // counters start at CTR_INIT; a RAM-based table could not do this.
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= CTR_INIT;
      end
    end else if (upd_write) begin
      // NOTE: state is written with non-blocking assignments so the lookup
      // and training logic all see the same pre-edge table.
      btb_q[upd_idx] <= upd_entry_d;
    end
  end

  // ---------------------------------------------------------------------
  // Mispredict detection and redirect
  // ---------------------------------------------------------------------
  // Wrong direction, or right "taken" with the wrong target.
  always_comb begin
    mispredict  = upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + PC_STEP;
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Saturating event counters; nothing counts in a reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd_valid) begin
      if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
